// File: rtl/mmio_monitor_pkg.sv
// Shared types and default addresses for the MMIO end-of-test monitor.
package mmio_monitor_pkg;

   typedef enum logic [1:0] {MON_RUN, MON_DRAIN, MON_DONE} mon_state_t;

   localparam logic [31:0] CONSOLE_ADDR_D = 32'h1000_0000;
   localparam logic [31:0] RESULT_ADDR_D  = 32'd100;
   localparam logic [31:0] IGNORE_ADDR_D  = 32'd96;

   // Width of a channel index; a single channel still needs one bit.
   function automatic int unsigned ch_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mon_sync_fifo.sv
// Console byte FIFO: single clock, extra pointer bit to tell full from empty.
module mon_sync_fifo #(
   parameter int unsigned WIDTH = 9,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [PW:0]      wptr_q, rptr_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             wr_en, rd_en;

   // A push on a full FIFO is accepted only when the head leaves in the same cycle.
   always_comb begin
      empty = (wptr_q == rptr_q);
      full  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
      wr_en = push && (!full || pop);
      rd_en = pop && !empty;
      rdata = mem_q[rptr_q[PW-1:0]];
   end

   // Storage and pointers; storage is cleared so the head reads 0 out of reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         if (wr_en) begin
            mem_q[wptr_q[PW-1:0]] <= wdata;
            wptr_q                <= wptr_q + 1'b1;
         end
         if (rd_en) rptr_q <= rptr_q + 1'b1;
      end
   end

endmodule

// File: rtl/mmio_test_monitor.sv
// End-of-test monitor: snoops store ports, buffers console bytes, tracks
// pass/fail mailbox writes and a watchdog, and raises done via RUN/DRAIN/DONE.
module mmio_test_monitor
   import mmio_monitor_pkg::*;
#(
   parameter int unsigned          NCH          = 2,
   parameter int unsigned          AW           = 32,
   parameter int unsigned          DW           = 32,
   parameter logic [AW-1:0]        CONSOLE_ADDR = AW'(CONSOLE_ADDR_D),
   parameter logic [AW-1:0]        RESULT_ADDR  = AW'(RESULT_ADDR_D),
   parameter logic [AW-1:0]        IGNORE_ADDR  = AW'(IGNORE_ADDR_D),
   parameter logic [NCH*DW-1:0]    PASS_VAL     = {32'd7, 32'd25},
   parameter bit                   STRICT       = 1'b0,
   parameter int unsigned          FIFO_DEPTH   = 8,
   parameter int unsigned          DRAIN_CYCLES = 4,
   parameter int unsigned          TIMEOUT      = 100,
   localparam int unsigned         CHW          = ch_width(NCH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NCH-1:0]    mem_we,
   input  logic [NCH*AW-1:0] mem_addr,
   input  logic [NCH*DW-1:0] mem_wdata,
   output logic              con_valid,
   input  logic              con_ready,
   output logic [7:0]        con_data,
   output logic [CHW-1:0]    con_ch,
   output logic              con_drop,
   output logic [NCH-1:0]    pass_mask,
   output logic              fail,
   output logic [CHW-1:0]    fail_ch,
   output logic              timeout,
   output logic              done
);

   localparam int unsigned    FW        = CHW + 8;
   localparam int unsigned    TCW       = $clog2(TIMEOUT + 2);
   localparam logic [TCW-1:0] TO_LIM    = TCW'(TIMEOUT);
   localparam logic [TCW-1:0] CNT_SAT   = (TIMEOUT == 0) ? TCW'(1) : TCW'(TIMEOUT);
   localparam int unsigned    DCW       = $clog2(DRAIN_CYCLES + 2);
   localparam logic [DCW-1:0] DRAIN_LIM = DCW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

   mon_state_t     state_q, state_d;
   logic [NCH-1:0] pass_q, pass_d, pass_set, fail_hit;
   logic           fail_q, fail_d, timeout_q, timeout_d, drop_q, drop_d;
   logic [CHW-1:0] fail_ch_q, fail_ch_d, fail_sel, con_sel;
   logic [TCW-1:0] cyc_q, cyc_d;
   logic [DCW-1:0] drain_q, drain_d;
   logic [7:0]     con_byte;
   logic           active, con_req, con_extra, fail_found, to_hit;
   logic           f_push, f_pop, f_full, f_empty;
   logic [FW-1:0]  f_rdata;

   // Decode every channel's store: console arbitration, pass values, strict failures.
   always_comb begin
      active     = (state_q != MON_DONE);
      con_req    = 1'b0;
      con_extra  = 1'b0;
      con_sel    = '0;
      con_byte   = '0;
      pass_set   = '0;
      fail_hit   = '0;
      fail_sel   = '0;
      fail_found = 1'b0;
      for (int ch = 0; ch < NCH; ch++) begin
         if (mem_we[ch] && active) begin
            if (mem_addr[ch*AW +: AW] == CONSOLE_ADDR) begin
               if (con_req) begin
                  con_extra = 1'b1;
               end else begin
                  con_req  = 1'b1;
                  con_sel  = CHW'(ch);
                  con_byte = mem_wdata[ch*DW +: 8];
               end
            end
            if (mem_addr[ch*AW +: AW] == RESULT_ADDR) begin
               if (mem_wdata[ch*DW +: DW] == PASS_VAL[ch*DW +: DW]) pass_set[ch] = 1'b1;
               else if (STRICT) fail_hit[ch] = 1'b1;
            end
            if (STRICT && mem_addr[ch*AW +: AW] != CONSOLE_ADDR &&
                mem_addr[ch*AW +: AW] != RESULT_ADDR && mem_addr[ch*AW +: AW] != IGNORE_ADDR) begin
               fail_hit[ch] = 1'b1;
            end
         end
         if (fail_hit[ch] && !fail_found) begin
            fail_found = 1'b1;
            fail_sel   = CHW'(ch);
         end
      end
   end

   // Sticky status, console push/drop and the saturating watchdog.
   always_comb begin
      f_pop     = !f_empty && con_ready;
      f_push    = con_req;
      drop_d    = drop_q | con_extra | (con_req & f_full & ~f_pop);
      pass_d    = pass_q | pass_set;
      fail_d    = fail_q | fail_found;
      fail_ch_d = (!fail_q && fail_found) ? fail_sel : fail_ch_q;
      cyc_d     = (cyc_q == CNT_SAT) ? cyc_q : cyc_q + 1'b1;
      to_hit    = (TIMEOUT != 0) && active && (cyc_d == TO_LIM);
      timeout_d = timeout_q | to_hit;
   end

   // Next state: any failure or expiry ends the test; all-pass waits out the drain.
   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      unique case (state_q)
         MON_RUN: begin
            if (fail_d || timeout_d) begin
               state_d = MON_DONE;
            end else if (&pass_d) begin
               state_d = MON_DRAIN;
               drain_d = '0;
            end
         end
         MON_DRAIN: begin
            if (fail_d || timeout_d) state_d = MON_DONE;
            else if (drain_q >= DRAIN_LIM && f_empty) state_d = MON_DONE;
            else if (drain_q < DRAIN_LIM) drain_d = drain_q + 1'b1;
         end
         MON_DONE: state_d = MON_DONE;
         default:  state_d = MON_DONE;
      endcase
   end

   // State registers; everything returns to zero / RUN on reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= MON_RUN;
         pass_q    <= '0;
         fail_q    <= 1'b0;
         fail_ch_q <= '0;
         timeout_q <= 1'b0;
         drop_q    <= 1'b0;
         cyc_q     <= '0;
         drain_q   <= '0;
      end else begin
         state_q   <= state_d;
         pass_q    <= pass_d;
         fail_q    <= fail_d;
         fail_ch_q <= fail_ch_d;
         timeout_q <= timeout_d;
         drop_q    <= drop_d;
         cyc_q     <= cyc_d;
         drain_q   <= drain_d;
      end
   end

   mon_sync_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (f_push),
      .pop   (f_pop),
      .wdata ({con_sel, con_byte}),
      .rdata (f_rdata),
      .full  (f_full),
      .empty (f_empty)
   );

   // Output mapping.
   always_comb begin
      con_valid = !f_empty;
      con_data  = f_rdata[7:0];
      con_ch    = f_rdata[FW-1:8];
      con_drop  = drop_q;
      pass_mask = pass_q;
      fail      = fail_q;
      fail_ch   = fail_ch_q;
      timeout   = timeout_q;
      done      = (state_q == MON_DONE);
   end

endmodule
